// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - fetch/data requester and memory-side signal bundle for mips_mem_arbiter
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - serialises fetch and load/store accesses onto one unified word memory
// MIPS_ARB_RR_EN selects round-robin; otherwise DM priority with an IF starvation guard.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mips_mem_arbiter_if.slave bus
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic [LW-1:0]   lat_cnt;
  logic            owner_dm;
  logic            pick_dm;

`ifdef MIPS_ARB_RR_EN
  logic rr_dm;

  always_comb begin
    pick_dm = bus.dm_req && (!bus.if_req || rr_dm);
  end
`else
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          force_if;

  // DM keeps priority unless fetch has watched STARVE_MAX DM grants in a row
  always_comb begin
    force_if = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);
    pick_dm  = bus.dm_req && !(bus.if_req && force_if);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      owner_dm      <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_gnt    <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.m_en      <= 1'b0;
      bus.m_we      <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_wdata   <= '0;
      bus.busy      <= 1'b0;
`ifdef MIPS_ARB_RR_EN
      rr_dm         <= 1'b1;
`else
      starve_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.if_rvalid <= 1'b0;
          bus.dm_rvalid <= 1'b0;
          if (bus.if_req || bus.dm_req) begin
            owner_dm    <= pick_dm;
            bus.m_en    <= 1'b1;
            bus.m_we    <= pick_dm && bus.dm_we;
            bus.m_addr  <= pick_dm ? bus.dm_addr : bus.if_addr;
            bus.m_wdata <= pick_dm ? bus.dm_wdata : '0;
            bus.dm_gnt  <= pick_dm;
            bus.if_gnt  <= !pick_dm;
            bus.busy    <= 1'b1;
            state       <= ISSUE;
`ifdef MIPS_ARB_RR_EN
            rr_dm       <= !pick_dm;
`else
            if (pick_dm && bus.if_req)
              starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
            else
              starve_cnt <= '0;
`endif
          end
        end
        ISSUE: begin
          bus.m_en   <= 1'b0;
          bus.if_gnt <= 1'b0;
          bus.dm_gnt <= 1'b0;
          lat_cnt    <= LW'(MEM_LAT - 1);
          state      <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            // m_we still reflects the access in flight, so it marks a store completion
            if (owner_dm) begin
              bus.dm_rvalid <= 1'b1;
              bus.dm_rdata  <= bus.m_we ? '0 : bus.m_rdata;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.m_rdata;
            end
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
